// File: rtl/abc_pkt_checker.sv
// Framing checker and statistics collector for the 64-bit abc packet stream.
// Produces one registered {len, xsum, err} result per packet plus saturating counters.
module abc_pkt_checker #(
  parameter int MAX_WORDS = 256,
  parameter int LEN_W     = $clog2(MAX_WORDS + 1),
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sop,
  input  logic             eop,
  input  logic [63:0]      data,
  output logic             done,
  output logic [LEN_W-1:0] res_len,
  output logic [63:0]      res_xsum,
  output logic [1:0]       res_err,
  output logic [CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int ENT_W = LEN_W + 66;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_IN_PKT  = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;

  localparam logic [1:0] ERR_OK     = 2'd0;
  localparam logic [1:0] ERR_TRUNC  = 2'd1;
  localparam logic [1:0] ERR_OVS    = 2'd2;
  localparam logic [1:0] ERR_ORPHAN = 2'd3;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);
  localparam logic [LEN_W-1:0] ONE_LEN = LEN_W'(1);

  logic [1:0]       state, state_nxt;
  logic [LEN_W-1:0] acc_len, acc_len_nxt;
  logic [63:0]      acc_xsum, acc_xsum_nxt;
  logic [1:0]       push_cnt;
  logic [ENT_W-1:0] push_a, push_b;
  logic [ENT_W-1:0] q0, q1, q0_nxt, q1_nxt, rem0;
  logic [1:0]       q_cnt, q_cnt_nxt, rem_cnt;
  logic             pop;

  function automatic logic [ENT_W-1:0] pack_res(input logic [LEN_W-1:0] l,
                                                input logic [63:0] x,
                                                input logic [1:0] e);
    return {l, x, e};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Framing FSM: decides the next accumulator and up to two results per cycle.
  always_comb begin
    state_nxt    = state;
    acc_len_nxt  = acc_len;
    acc_xsum_nxt = acc_xsum;
    push_cnt     = 2'd0;
    push_a       = '0;
    push_b       = '0;
    case (state)
      ST_IDLE: begin
        if (sop && !eop) begin
          state_nxt    = ST_IN_PKT;
          acc_len_nxt  = ONE_LEN;
          acc_xsum_nxt = data;
        end else if (sop && eop) begin
          push_cnt = 2'd1;
          push_a   = pack_res(ONE_LEN, data, ERR_OK);
        end else if (eop) begin
          push_cnt = 2'd1;
          push_a   = pack_res('0, '0, ERR_ORPHAN);
        end
      end
      ST_IN_PKT: begin
        if (!sop && !eop) begin
          if (acc_len < MAX_LEN) begin
            acc_len_nxt  = acc_len + ONE_LEN;
            acc_xsum_nxt = acc_xsum ^ data;
          end else begin
            push_cnt  = 2'd1;
            push_a    = pack_res(MAX_LEN, acc_xsum, ERR_OVS);
            state_nxt = ST_DISCARD;
          end
        end else if (!sop && eop) begin
          push_cnt  = 2'd1;
          state_nxt = ST_IDLE;
          if (acc_len < MAX_LEN) push_a = pack_res(acc_len + ONE_LEN, acc_xsum ^ data, ERR_OK);
          else                   push_a = pack_res(MAX_LEN, acc_xsum, ERR_OVS);
        end else if (!eop) begin
          push_cnt     = 2'd1;
          push_a       = pack_res(acc_len, acc_xsum, ERR_TRUNC);
          acc_len_nxt  = ONE_LEN;
          acc_xsum_nxt = data;
        end else begin
          // Old packet is reported ahead of the single-word packet that cut it short.
          push_cnt  = 2'd2;
          push_a    = pack_res(acc_len, acc_xsum, ERR_TRUNC);
          push_b    = pack_res(ONE_LEN, data, ERR_OK);
          state_nxt = ST_IDLE;
        end
      end
      ST_DISCARD: begin
        if (sop && !eop) begin
          state_nxt    = ST_IN_PKT;
          acc_len_nxt  = ONE_LEN;
          acc_xsum_nxt = data;
        end else if (sop && eop) begin
          push_cnt  = 2'd1;
          push_a    = pack_res(ONE_LEN, data, ERR_OK);
          state_nxt = ST_IDLE;
        end else if (eop) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Result queue: pop first, then append this cycle's pushes behind what remains.
  always_comb begin
    pop     = (q_cnt != 2'd0);
    rem_cnt = q_cnt - {1'b0, pop};
    rem0    = pop ? q1 : q0;
    q0_nxt  = q0;
    q1_nxt  = q1;
    case (rem_cnt)
      2'd0: begin
        q0_nxt = push_a;
        q1_nxt = push_b;
      end
      2'd1: begin
        q0_nxt = rem0;
        q1_nxt = push_a;
      end
      default: ;
    endcase
    q_cnt_nxt = rem_cnt + push_cnt;
  end

  always_ff @(posedge clk) begin
    q0 <= q0_nxt;
    q1 <= q1_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      acc_len   <= '0;
      acc_xsum  <= '0;
      q_cnt     <= 2'd0;
      done      <= 1'b0;
      res_len   <= '0;
      res_xsum  <= '0;
      res_err   <= 2'd0;
      pkt_count <= '0;
      err_count <= '0;
    end else begin
      state    <= state_nxt;
      acc_len  <= acc_len_nxt;
      acc_xsum <= acc_xsum_nxt;
      q_cnt    <= q_cnt_nxt;
      done     <= pop;
      if (pop) begin
        res_len  <= q0[ENT_W-1 -: LEN_W];
        res_xsum <= q0[65:2];
        res_err  <= q0[1:0];
        if (q0[1:0] == ERR_OK) pkt_count <= sat_inc(pkt_count);
        else                   err_count <= sat_inc(err_count);
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    ({1'b0, rem_cnt} + {1'b0, push_cnt}) <= 3'd2);

endmodule

// File: tb/tb_abc_pkt_checker.sv
// Scoreboard bench for abc_pkt_checker: tasks queue expected results with their due cycle,
// a negedge monitor pops and compares them whenever done is seen.
module tb_abc_pkt_checker;
  localparam int MAXW = 4;
  localparam int LW   = $clog2(MAXW + 1);

  logic        clk = 1'b0;
  logic        rst_n, sop, eop;
  logic [63:0] data;

  logic          done, done_s;
  logic [LW-1:0] res_len, res_len_s;
  logic [63:0]   res_xsum, res_xsum_s;
  logic [1:0]    res_err, res_err_s;
  logic [15:0]   pkt_count, err_count;
  logic [1:0]    pkt_count_s, err_count_s;

  abc_pkt_checker #(.MAX_WORDS(MAXW), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .sop(sop), .eop(eop), .data(data),
    .done(done), .res_len(res_len), .res_xsum(res_xsum), .res_err(res_err),
    .pkt_count(pkt_count), .err_count(err_count));

  abc_pkt_checker #(.MAX_WORDS(MAXW), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .sop(sop), .eop(eop), .data(data),
    .done(done_s), .res_len(res_len_s), .res_xsum(res_xsum_s), .res_err(res_err_s),
    .pkt_count(pkt_count_s), .err_count(err_count_s));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          len;
    logic [63:0] xsum;
    int          err;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  int tests = 0;
  int fails = 0;
  int model_pkt = 0;
  int model_err = 0;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n) begin
      model_pkt = 0;
      model_err = 0;
    end else if (done === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done: got len=%0d xsum=%h err=%0d at cycle %0d, required no result",
                 res_len, res_xsum, res_err, cyc);
      end else begin
        e = exp_q.pop_front();
        if (res_len !== LW'(e.len)) begin
          fails++;
          $display("FAIL res_len: got %0d, required %0d", res_len, e.len);
        end
        tests++;
        if (res_xsum !== e.xsum) begin
          fails++;
          $display("FAIL res_xsum: got %h, required %h", res_xsum, e.xsum);
        end
        tests++;
        if (res_err !== 2'(e.err)) begin
          fails++;
          $display("FAIL res_err: got %0d, required %0d", res_err, e.err);
        end
        tests++;
        if (cyc != e.cyc) begin
          fails++;
          $display("FAIL done_cycle: got cycle %0d, required %0d", cyc, e.cyc);
        end
        if (e.err == 0) model_pkt++;
        else            model_err++;
        tests++;
        if (pkt_count !== 16'(model_pkt) || err_count !== 16'(model_err)) begin
          fails++;
          $display("FAIL counters: got pkt=%0d err=%0d, required pkt=%0d err=%0d",
                   pkt_count, err_count, model_pkt, model_err);
        end
        tests++;
        if (pkt_count_s !== 2'((model_pkt > 3) ? 3 : model_pkt) ||
            err_count_s !== 2'((model_err > 3) ? 3 : model_err)) begin
          fails++;
          $display("FAIL sat_counters: got pkt=%0d err=%0d, required pkt=%0d err=%0d",
                   pkt_count_s, err_count_s, (model_pkt > 3) ? 3 : model_pkt,
                   (model_err > 3) ? 3 : model_err);
        end
      end
    end
  end

  task automatic drive(input logic s, input logic e, input logic [63:0] d);
    sop  = s;
    eop  = e;
    data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_res(input int l, input logic [63:0] x, input int er, input int dly);
    exp_t t;
    t.len  = l;
    t.xsum = x;
    t.err  = er;
    t.cyc  = cyc + dly;
    exp_q.push_back(t);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, {$urandom, $urandom});
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 10) begin
      idle(1);
      k++;
    end
    idle(3);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: %0d results outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sop   = 1'b0;
    eop   = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sop   = 1'b0;
    eop   = 1'b0;
    data  = '0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (done !== 1'b0 || res_len !== '0 || res_xsum !== '0 || res_err !== 2'd0) begin
      fails++;
      $display("FAIL reset_res: got done=%b len=%0d xsum=%h err=%0d, required all 0",
               done, res_len, res_xsum, res_err);
    end
    tests++;
    if (pkt_count !== '0 || err_count !== '0 || pkt_count_s !== '0 || err_count_s !== '0) begin
      fails++;
      $display("FAIL reset_counts: got pkt=%0d err=%0d, required 0", pkt_count, err_count);
    end
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 64'h100);
    drive(1'b0, 1'b0, 64'h200);
    drive(1'b0, 1'b0, 64'h300);
    drive(1'b0, 1'b0, 64'h400);
    rst_n = 1'b0;
    sop   = 1'b0;
    #1;
    tests++;
    if (done !== 1'b0 || res_len !== '0 || res_xsum !== '0 || res_err !== 2'd0 ||
        pkt_count !== '0 || err_count !== '0) begin
      fails++;
      $display("FAIL reset_midpkt: got done=%b len=%0d xsum=%h err=%0d, required all 0",
               done, res_len, res_xsum, res_err);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 64'h5);
    expect_res(2, 64'h3, 0, 2);
    drive(1'b0, 1'b1, 64'h6);
    drain("reset");
    tests++;
    if (pkt_count !== 16'd1) begin
      fails++;
      $display("FAIL reset_after_pkt: got pkt_count=%0d, required 1", pkt_count);
    end
  endtask

  task automatic test_normal();
    do_reset();
    drive(1'b1, 1'b0, 64'h1);
    drive(1'b0, 1'b0, 64'h2);
    drive(1'b0, 1'b0, 64'h3);
    expect_res(4, 64'h4, 0, 2);
    drive(1'b0, 1'b1, 64'h4);
    drain("normal");
    tests++;
    if (pkt_count !== 16'd1 || err_count !== 16'd0) begin
      fails++;
      $display("FAIL normal_counts: got pkt=%0d err=%0d, required 1 0", pkt_count, err_count);
    end
    tests++;
    if (done !== 1'b0 || res_len !== LW'(4) || res_xsum !== 64'h4) begin
      fails++;
      $display("FAIL normal_hold: got done=%b len=%0d xsum=%h, required 0 4 4",
               done, res_len, res_xsum);
    end
  endtask

  task automatic test_single();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      expect_res(1, 64'(10 + i), 0, 2);
      drive(1'b1, 1'b1, 64'(10 + i));
    end
    drain("single");
    tests++;
    if (pkt_count !== 16'd5 || pkt_count_s !== 2'd3) begin
      fails++;
      $display("FAIL single_counts: got pkt=%0d sat=%0d, required 5 3", pkt_count, pkt_count_s);
    end
  endtask

  task automatic test_sop_eop_mid();
    do_reset();
    drive(1'b1, 1'b0, 64'h11);
    drive(1'b0, 1'b0, 64'h22);
    expect_res(2, 64'h33, 1, 2);
    expect_res(1, 64'h33, 0, 3);
    drive(1'b1, 1'b1, 64'h33);
    drain("sop_eop_mid");
    tests++;
    if (pkt_count !== 16'd1 || err_count !== 16'd1) begin
      fails++;
      $display("FAIL sop_eop_mid_counts: got pkt=%0d err=%0d, required 1 1", pkt_count, err_count);
    end
  endtask

  task automatic test_oversize();
    do_reset();
    drive(1'b1, 1'b0, 64'h1);
    repeat (3) drive(1'b0, 1'b0, 64'h1);
    expect_res(4, 64'h0, 2, 2);
    drive(1'b0, 1'b0, 64'h1);
    drive(1'b0, 1'b1, 64'h1);
    drain("oversize");
    drive(1'b1, 1'b0, 64'h5);
    drive(1'b0, 1'b0, 64'h6);
    drive(1'b0, 1'b0, 64'h7);
    expect_res(4, 64'hC, 0, 2);
    drive(1'b0, 1'b1, 64'h8);
    drain("exact_max");
    drive(1'b1, 1'b0, 64'h10);
    drive(1'b0, 1'b0, 64'h20);
    drive(1'b0, 1'b0, 64'h30);
    drive(1'b0, 1'b0, 64'h40);
    expect_res(4, 64'h40, 2, 2);
    drive(1'b0, 1'b0, 64'h50);
    drive(1'b0, 1'b0, 64'h60);
    expect_res(1, 64'h77, 0, 2);
    drive(1'b1, 1'b1, 64'h77);
    drain("discard_sop_eop");
    tests++;
    if (pkt_count !== 16'd2 || err_count !== 16'd2) begin
      fails++;
      $display("FAIL oversize_counts: got pkt=%0d err=%0d, required 2 2", pkt_count, err_count);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1'b1, 1'b0, 64'h1);
    drive(1'b0, 1'b0, 64'h2);
    expect_res(2, 64'h3, 1, 2);
    drive(1'b1, 1'b0, 64'h3);
    expect_res(2, 64'h7, 0, 2);
    drive(1'b0, 1'b1, 64'h4);
    expect_res(1, 64'h9, 0, 2);
    drive(1'b1, 1'b1, 64'h9);
    drive(1'b1, 1'b0, 64'hA);
    expect_res(1, 64'hA, 1, 2);
    expect_res(1, 64'hB, 0, 3);
    drive(1'b1, 1'b1, 64'hB);
    // The queue still holds 0xB, so this result waits one extra cycle.
    expect_res(1, 64'hC, 0, 3);
    drive(1'b1, 1'b1, 64'hC);
    drain("back_to_back");
    tests++;
    if (pkt_count !== 16'd4 || err_count !== 16'd2) begin
      fails++;
      $display("FAIL back_to_back_counts: got pkt=%0d err=%0d, required 4 2", pkt_count, err_count);
    end
  endtask

  task automatic test_orphan();
    do_reset();
    expect_res(0, 64'h0, 3, 2);
    drive(1'b0, 1'b1, 64'h55);
    idle(2);
    for (int i = 0; i < 5; i++) begin
      expect_res(0, 64'h0, 3, 2);
      drive(1'b0, 1'b1, {$urandom, $urandom});
    end
    drain("orphan");
    tests++;
    if (err_count !== 16'd6 || err_count_s !== 2'd3 || pkt_count_s !== 2'd0) begin
      fails++;
      $display("FAIL orphan_sat: got err=%0d sat_err=%0d sat_pkt=%0d, required 6 3 0",
               err_count, err_count_s, pkt_count_s);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_single();
    test_sop_eop_mid();
    test_oversize();
    test_back_to_back();
    test_orphan();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit, required completion");
    $fatal(1);
  end

endmodule

// File: doc/abc_pkt_checker.md
# abc_pkt_checker

Framing checker and statistics collector for the 64-bit abc packet stream. It sits directly downstream of the two-cycle abc delay stage and consumes that stage's output port: sop, eop and 64-bit data, one word per clock, no valid or ready. For every packet it produces a registered result: word count, XOR checksum and error code. It also keeps saturating packet and error counters for the test layer.

## Interface
Parameters:
- MAX_WORDS, 256: maximum legal packet length in words (≥2).
- LEN_W, $clog2(MAX_WORDS+1): width of the length field.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  clock; the same clock that drives the abc port.
- rst_n  in  1  reset. Asynchronous, active-low.
- sop  in  1  start of packet; sampled every posedge.
- eop  in  1  end of packet; sampled every posedge.
- data  in  64  packet word; ignored outside a packet.
- done  out  1  one-cycle pulse; a result is presented on res_*.
- res_len  out  LEN_W  words counted in the reported packet.
- res_xsum  out  64  XOR of the counted words.
- res_err  out  2  result code: 0 OK, 1 TRUNCATED, 2 OVERSIZE, 3 ORPHAN_EOP.
- pkt_count  out  CNT_W  results with res_err=0; saturates at all-ones.
- err_count  out  CNT_W  results with res_err≠0; saturates at all-ones.

## Operation
- The framing FSM has three states: IDLE, IN_PKT and DISCARD. It keeps an accumulator for len and xsum.
- In IDLE:
  - sop&!eop: go to IN_PKT; len=1, xsum=data.
  - sop&eop: push {1, data, OK}.
  - !sop&eop: push {0, 0, ORPHAN_EOP}.
  - Otherwise: stay in IDLE.
- In IN_PKT:
  - !sop&!eop: if len<MAX_WORDS, then len+1 and xsum^=data. Otherwise push {MAX_WORDS, xsum, OVERSIZE} and go to DISCARD.
  - !sop&eop: if len<MAX_WORDS, push {len+1, xsum^data, OK} and go to IDLE. Otherwise push {MAX_WORDS, xsum, OVERSIZE} and go to IDLE.
  - sop&!eop: push {len, xsum, TRUNCATED}; restart with len=1, xsum=data; stay in IN_PKT.
  - sop&eop: push {len, xsum, TRUNCATED}, then push {1, data, OK} in the same cycle, old packet first; go to IDLE.
- In DISCARD, words are dropped:
  - eop alone: go to IDLE.
  - sop&!eop: go to IN_PKT with len=1, xsum=data.
  - sop&eop: push {1, data, OK}; go to IDLE.
  - The oversize packet is never reported a second time.
- Result queue:
  - 2-entry FIFO; 0, 1 or 2 pushes per cycle; at most one pop per cycle.
  - Pop whenever the queue is non-empty at the posedge. The popped entry drives res_* and done for the following cycle.
  - The queue cannot overflow. A double push only occurs leaving IN_PKT. Re-entering IN_PKT needs a push-free sop&!eop cycle, and that cycle drains one entry.
  - Overflow is therefore a design error; it is flagged by an assertion and has no recovery path.
- Counters update on each done pulse, based on res_err.
  - Both counters saturate at 2^CNT_W−1 and never wrap.
- res_* hold the last popped result while done=0.

## Timing
- Reset: state=IDLE, queue empty, accumulator 0. done, res_len, res_xsum, res_err, pkt_count and err_count are all 0.
- Reset takes effect immediately; a packet in progress is lost without a result.
- The first sampling edge after rst_n rises is treated as IDLE.
- Latency:
  - With the queue empty, a result pushed at posedge N gives done=1 during cycle N+1.
  - The second entry of a double push appears at N+2.
- A single-cycle packet (sop&eop) is legal at any time, including back-to-back every cycle; this gives done every cycle.
- A packet of exactly MAX_WORDS words closing with eop is OK. Word MAX_WORDS+1 produces OVERSIZE on the next pop.
- data is never checked for X outside a packet.

## Test plan
- Reset mid-packet: sop, 3 words, then rst_n=0 for 2 cycles -> all outputs 0, no done; a following 2-word packet reports len=2, OK.
- Normal packet: data 1,2,3,4 with sop on word 1 and eop on word 4 -> done one cycle after eop; len=4, xsum=0x4, err=0; pkt_count=1.
- Single words: 5 consecutive sop&eop cycles with data=0xA..0xE -> 5 consecutive done pulses, each len=1 with xsum equal to its data; pkt_count=5.
- sop&eop mid-packet: sop+0x11, 0x22, then sop&eop with 0x33 -> done on two consecutive cycles: {2, 0x33, TRUNCATED} then {1, 0x33, OK}; err_count=1, pkt_count=1.
- Oversize (MAX_WORDS=4):
  - A 6-word packet of 0x1 words -> one result {4, 0x0, OVERSIZE}; words 5 and 6 are discarded; no further done.
  - A following 4-word packet -> OK with len=4.
- Orphan eop and saturation (CNT_W=2):
  - An eop while IDLE -> {0, 0, ORPHAN_EOP}.
  - 5 orphan eops -> err_count holds at 3.
